demod_i2s_tx: RTL
=================

Name: demod_i2s_tx

Overview:
- Audio output stage directly downstream of the AM demodulator.
- Consumes the signed 18-bit demodulated samples and their slow sample strobe, and buffers them in a 4-deep FIFO.
- Serialises each sample as a mono I2S stream (same word in left and right slots) for an external audio DAC.
- Rate mismatch between the demod sample rate and the I2S frame rate is absorbed by dropping samples (overrun) or repeating them (underrun), each reported by a sticky flag.

Parameters:
- DATA_W, 18, sample width in bits; must be ≤ SLOT_W-1.
- SLOT_W, 32, I2S bits per channel slot; frame = 2*SLOT_W BCLK periods.
- BCLK_DIV, 98, clk cycles per BCLK half-period. At clk = 125 MHz the frame rate is ≈ 9.96 kHz.
- FIFO_DEPTH, 4, sample buffer depth; must be a power of 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- demod_in  in  18  signed sample from the demodulator; stable for the full demod_clk period after its rising edge.
- demod_clk  in  1  demod sample strobe; a slow square wave, treated as asynchronous.
- clear_flags  in  1  one-cycle pulse that clears overrun and underrun.
- i2s_bclk  out  1  I2S bit clock.
- i2s_lrclk  out  1  word select: 0 = left slot, 1 = right slot.
- i2s_sdata  out  1  serial data, MSB first.
- fifo_level  out  3  number of samples in the FIFO, 0..4.
- overrun  out  1  sticky; a sample was dropped because the FIFO was full.
- underrun  out  1  sticky; a frame started with the FIFO empty.

Behaviour:
- Reset (async assert, sync release) state:
  - i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0.
  - fifo_level=0, overrun=0, underrun=0.
  - FIFO pointers=0, output word register=0, bit index b=2*SLOT_W-1, divider count=0.
  - Reset mid-frame discards all FIFO content and the frame in progress.
- Input capture:
  - demod_clk passes through a 2-FF synchroniser, then a rising-edge detector.
  - On the detected edge cycle, demod_in is written to the FIFO. Write latency from the demod_clk edge is 3 clk.
- FIFO write rules:
  - Full and no pop in the same cycle: sample is dropped and overrun is set.
  - Full and a pop in the same cycle: write is accepted and level stays at 4.
- BCLK generation:
  - Divider counts 0..BCLK_DIV-1; i2s_bclk toggles on wrap.
  - The first rising BCLK edge is BCLK_DIV cycles after reset release.
  - All I2S outputs change only in the clk cycle where i2s_bclk goes 1→0 (falling-edge event).
- Frame sequencing, on each falling-edge event:
  - b advances modulo 2*SLOT_W.
  - i2s_lrclk = (b ≥ SLOT_W).
  - Slot bit k = b mod SLOT_W.
  - i2s_sdata = word[DATA_W-k] for 1 ≤ k ≤ DATA_W, else 0. This gives the I2S one-BCLK MSB delay and zero-padded tail.
  - Data is stable across the BCLK rising edge.
- Frame load (the falling-edge event where b becomes 0):
  - FIFO non-empty: pop the oldest sample into word.
  - FIFO empty: word holds its previous value and underrun is set.
  - The same word is sent in both slots.
  - If a write lands in the same cycle the FIFO is empty, the pop is not taken; the write is stored and underrun is still set.
- fifo_level = writes − pops. It updates one cycle after the write or pop and is never outside 0..4.
- Flags:
  - overrun and underrun stay at 1 until clear_flags or reset.
  - If clear_flags coincides with a new set event, set wins.
- Signed arithmetic: word is sent unmodified as two's complement. There is no scaling or saturation.

Test Plan:
- Reset values: assert reset_n=0 mid-frame with the FIFO holding 2 samples → all outputs at reset values immediately (async). After release, first i2s_bclk rise occurs at clk cycle BCLK_DIV.
- Single word: BCLK_DIV=2; push demod_in=18'h2A5A5 → left-slot sdata bits k1..k18 = 1,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1. Bits k0 and k19..31 = 0. Right slot is identical. lrclk toggles every 32 BCLKs.
- Negative value: push 18'h3FFFF (−1) → 18 ones per slot, then zeros; fifo_level goes 1→0 at frame load.
- Overrun: BCLK_DIV=98, 6 demod_clk edges within one frame → fifo_level=4, overrun=1; the first 4 samples are emitted in order over the next 4 frames.
- Underrun/repeat: one sample 18'h00123, no further input → 3 consecutive frames carry 18'h00123, underrun=1 after the second frame load. A clear_flags pulse → underrun=0 until the next empty load.
- Simultaneous events: demod_clk edge aligned so the write lands on the frame-load cycle with the FIFO full → level stays 4, overrun stays 0. Same alignment with the FIFO empty → level becomes 1, underrun=1, previous word is repeated.

Source files
------------

// File: rtl/demod_i2s_tx_if.sv
// rtl/demod_i2s_tx_if.sv - sample input and I2S output signal bundle
// Purpose: groups the demodulator sample inputs and the serial I2S outputs.
// Signals: demod_in (signed sample), demod_clk (slow sample strobe),
//          i2s_bclk, i2s_lrclk, i2s_sdata (serial audio to the DAC).
// Modports: master drives samples and observes I2S; slave is the transmitter.
interface demod_i2s_tx_if #(
    parameter int DATA_W = 18
);
    logic signed [DATA_W-1:0] demod_in;
    logic                     demod_clk;
    logic                     i2s_bclk;
    logic                     i2s_lrclk;
    logic                     i2s_sdata;

    modport master (
        output demod_in,
        output demod_clk,
        input  i2s_bclk,
        input  i2s_lrclk,
        input  i2s_sdata
    );

    modport slave (
        input  demod_in,
        input  demod_clk,
        output i2s_bclk,
        output i2s_lrclk,
        output i2s_sdata
    );
endinterface

// File: rtl/demod_i2s_tx.sv
// rtl/demod_i2s_tx.sv - demodulated sample FIFO and mono I2S serialiser
// Purpose: captures demod samples on the demod_clk strobe into a small FIFO
//          and sends each one in both slots of a 2*SLOT_W-bit I2S frame.
//          Overflow drops samples, an empty FIFO at frame start repeats the
//          previous word; both conditions raise sticky flags.
// Ports: clk, reset_n (async assert, active-low)
//        bus.slave: demod_in, demod_clk in; i2s_bclk, i2s_lrclk, i2s_sdata out
//        clear_flags in; fifo_level, overrun, underrun out
module demod_i2s_tx #(
    parameter int DATA_W     = 18,
    parameter int SLOT_W     = 32,
    parameter int BCLK_DIV   = 98,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    demod_i2s_tx_if.slave                   bus,
    input  logic                            clear_flags,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            overrun,
    output logic                            underrun
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int B_W   = $clog2(2 * SLOT_W);
    localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [B_W-1:0]   B_LAST   = B_W'(2 * SLOT_W - 1);
    localparam logic [B_W-1:0]   SLOT_B   = B_W'(SLOT_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // [0],[1] synchronise the asynchronous strobe, [2] holds the previous value
    logic [2:0]        dclk_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              bclk_q;
    logic [B_W-1:0]    b_q;
    logic              lrclk_q;
    logic              sdata_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;

    logic              wr_stb;
    logic              div_wrap;
    logic              fall_evt;
    logic              frame_load;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push;
    logic              ov_set;
    logic              un_set;
    logic [B_W-1:0]    b_next;
    logic [B_W-1:0]    slot_k;
    logic [SLOT_W-1:0] slot_word;
    logic [SLOT_W-1:0] slot_shift;
    logic              next_sdata;

    assign wr_stb     = dclk_q[1] & ~dclk_q[2];
    assign div_wrap   = (cnt_q == CNT_LAST);
    // Outputs move only when BCLK is about to fall
    assign fall_evt   = div_wrap & bclk_q;
    assign frame_load = fall_evt & (b_q == B_LAST);
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_FULL);
    assign pop        = frame_load & ~fifo_empty;
    // A full FIFO still accepts a write if the frame load frees a slot
    assign push       = wr_stb & (~fifo_full | pop);
    assign ov_set     = wr_stb & fifo_full & ~pop;
    assign un_set     = frame_load & fifo_empty;

    always_comb begin
        b_next     = (b_q == B_LAST) ? '0 : b_q + 1'b1;
        slot_k     = (b_next >= SLOT_B) ? b_next - SLOT_B : b_next;
        // Slot image: one leading zero (I2S MSB delay), the word, zero tail
        slot_word  = {{(SLOT_W - DATA_W){1'b0}}, word_q} << (SLOT_W - 1 - DATA_W);
        slot_shift = slot_word << slot_k;
        next_sdata = slot_shift[SLOT_W-1];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.demod_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dclk_q   <= '0;
            cnt_q    <= '0;
            bclk_q   <= 1'b0;
            b_q      <= B_LAST;
            lrclk_q  <= 1'b1;
            sdata_q  <= 1'b0;
            word_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            dclk_q <= {dclk_q[1:0], bus.demod_clk};

            if (div_wrap) begin
                cnt_q  <= '0;
                bclk_q <= ~bclk_q;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
            end

            if (fall_evt) begin
                b_q     <= b_next;
                lrclk_q <= (b_next >= SLOT_B);
                sdata_q <= next_sdata;
            end

            if (pop) begin
                word_q   <= mem[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end

            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end

            // A new event in the same cycle as clear_flags keeps the flag set
            if (ov_set) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
            if (un_set) begin
                underrun <= 1'b1;
            end else if (clear_flags) begin
                underrun <= 1'b0;
            end
        end
    end

    assign bus.i2s_bclk  = bclk_q;
    assign bus.i2s_lrclk = lrclk_q;
    assign bus.i2s_sdata = sdata_q;
    assign fifo_level    = level_q;
endmodule
